// File: rtl/mpu_arb_pkg.sv
// Shared definitions for the MPU SPI register-access arbiter: FSM state
// encoding and read/write select constants.
package mpu_arb_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_ISSUE     = 3'd1;
  localparam state_t ST_WAIT_RISE = 3'd2;
  localparam state_t ST_WAIT_FALL = 3'd3;
  localparam state_t ST_DONE      = 3'd4;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request scanning
// upward from ptr_i+1 (wrapping), as both a one-hot vector and an index.
module rr_pick #(
  parameter  int unsigned N  = 3,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  int unsigned   cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the scan infers a latch.
    valid_o  = 1'b0;
    gnt_o    = '0;
    idx_o    = '0;
    cand     = '0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = 32'(ptr_i) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IW'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o         = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mpu_spi_arbiter.sv
// Round-robin arbiter sharing one SPI register-access engine between NUM_REQ
// clients. Define MPU_ARB_TIMEOUT_EN to enable the busy-high watchdog (err_o).
module mpu_spi_arbiter
  import mpu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned ADDR_W         = 7,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned BUSY_RISE_MAX  = 15,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        req_rw_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      err_o,
  output logic [ADDR_W-1:0]         mpu_address_o,
  output logic [DATA_W-1:0]         mpu_wr_data_o,
  output logic                      mpu_rd_wr_sel_o,
  output logic                      mpu_start_o,
  input  logic                      mpu_busy_i,
  input  logic [DATA_W-1:0]         mpu_rd_data_i
);

  localparam int unsigned IW     = $clog2(NUM_REQ);
  localparam int unsigned RISE_W = $clog2(BUSY_RISE_MAX + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

`ifdef MPU_ARB_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q;
  logic [IW-1:0]       rr_ptr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                rw_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [RISE_W-1:0]   rise_cnt_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic                err_q;
  logic                timed_out_q;

  logic                pick_valid;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IW-1:0]       pick_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_rw;
  logic                rise_last;
  logic                to_hit;
  logic                take;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i   (req_i),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_valid),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_rw    = RD;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (pick_gnt[i]) begin
        sel_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata_i[i*DATA_W +: DATA_W];
        sel_rw    = req_rw_i[i];
      end
    end
  end

  assign take      = (state_q == ST_IDLE) && pick_valid && !mpu_busy_i;
  assign rise_last = (rise_cnt_q == RISE_W'(BUSY_RISE_MAX - 1));
  // Watchdog fires on the last allowed busy-high cycle; compiled out when disabled.
  assign to_hit    = TimeoutEn && (state_q == ST_WAIT_FALL) && mpu_busy_i &&
                     (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (take) state_d = ST_ISSUE;
      ST_ISSUE:     state_d = ST_WAIT_RISE;
      ST_WAIT_RISE: if (mpu_busy_i) state_d = ST_WAIT_FALL;
                    else if (rise_last) state_d = ST_DONE;
      ST_WAIT_FALL: if (!mpu_busy_i || to_hit) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mpu_start_o = (state_q == ST_ISSUE);
    done_o      = (state_q == ST_DONE) ? grant_q : '0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      grant_q     <= '0;
      rr_ptr_q    <= IW'(NUM_REQ - 1);
      addr_q      <= '0;
      wdata_q     <= '0;
      rw_q        <= RD;
      rdata_q     <= '0;
      rise_cnt_q  <= '0;
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      rise_cnt_q <= (state_q == ST_WAIT_RISE) ? rise_cnt_q + 1'b1 : '0;
      to_cnt_q   <= (TimeoutEn && state_q == ST_WAIT_FALL) ? to_cnt_q + 1'b1 : '0;
      if (take) begin
        grant_q  <= pick_gnt;
        rr_ptr_q <= pick_idx;
        addr_q   <= sel_addr;
        wdata_q  <= sel_wdata;
        rw_q     <= sel_rw ? RD : WR;
      end
      if (to_hit) begin
        err_q       <= 1'b1;
        timed_out_q <= 1'b1;
      end
      if (state_q == ST_DONE) begin
        if (rw_q == RD) rdata_q <= timed_out_q ? '1 : mpu_rd_data_i;
        grant_q     <= '0;
        timed_out_q <= 1'b0;
      end
    end
  end

  assign grant_o         = grant_q;
  assign rdata_o         = rdata_q;
  assign err_o           = err_q;
  assign mpu_address_o   = addr_q;
  assign mpu_wr_data_o   = wdata_q;
  assign mpu_rd_wr_sel_o = rw_q;

endmodule

// File: tb/tb_mpu_spi_arbiter.sv
// Scoreboard bench for mpu_spi_arbiter: directed transactions push expected
// start/done events; a monitor pops and compares as the DUT presents them.
module tb_mpu_spi_arbiter;
  import mpu_arb_pkg::*;

  localparam int unsigned NUM_REQ        = 3;
  localparam int unsigned ADDR_W         = 7;
  localparam int unsigned DATA_W         = 8;
  localparam int unsigned BUSY_RISE_MAX  = 15;
  localparam int unsigned TIMEOUT_CYCLES = 100;

  typedef struct packed {
    logic [2:0] grant;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
  } start_exp_t;

  typedef struct packed {
    logic [2:0] done;
    logic [7:0] rdata;
    int         lat;
  } done_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, req_rw;
  logic [20:0] req_addr;
  logic [23:0] req_wdata;
  logic [2:0]  grant, done;
  logic [7:0]  rdata;
  logic        err;
  logic [6:0]  mpu_address;
  logic [7:0]  mpu_wr_data;
  logic        mpu_rd_wr_sel, mpu_start, mpu_busy;
  logic [7:0]  mpu_rd_data;

  int          n_checks = 0;
  int          n_bad    = 0;
  int          cyc      = 0;
  start_exp_t  start_q[$];
  done_exp_t   done_q[$];
  int          eng_mode;
  int          eng_len;
  logic [7:0]  eng_rdata;
  logic [7:0]  exp_rd;

  mpu_spi_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .BUSY_RISE_MAX(BUSY_RISE_MAX), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk_i(clk), .reset_i(rst),
    .req_i(req), .req_rw_i(req_rw), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .grant_o(grant), .done_o(done), .rdata_o(rdata), .err_o(err),
    .mpu_address_o(mpu_address), .mpu_wr_data_o(mpu_wr_data),
    .mpu_rd_wr_sel_o(mpu_rd_wr_sel), .mpu_start_o(mpu_start),
    .mpu_busy_i(mpu_busy), .mpu_rd_data_i(mpu_rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_client(input int i, input logic rw, input logic [6:0] a, input logic [7:0] d);
    req_rw[i]            = rw;
    req_addr[i*7 +: 7]   = a;
    req_wdata[i*8 +: 8]  = d;
  endtask

  task automatic exp_start(input logic [2:0] g, input logic [6:0] a, input logic rw, input logic [7:0] d);
    start_exp_t e;
    e.grant = g; e.addr = a; e.rw = rw; e.wdata = d;
    start_q.push_back(e);
  endtask

  task automatic exp_done(input logic [2:0] g, input logic [7:0] rd, input int lat);
    done_exp_t e;
    e.done = g; e.rdata = rd; e.lat = lat;
    done_q.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (done == '0 && k < budget);
    check("done within budget", 32'(done != '0), 32'd1);
  endtask

  task automatic wait_start(input int budget);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!mpu_start && k < budget);
    check("start within budget", 32'(mpu_start), 32'd1);
  endtask

  // Engine model: busy rises the cycle after start is taken.
  // Mode 0: busy for eng_len cycles then returns eng_rdata; 1: never busy; 2: stuck until done.
  initial begin : engine
    mpu_busy    = 1'b0;
    mpu_rd_data = '0;
    forever begin
      @(posedge clk); #1;
      if (mpu_start && !rst && eng_mode != 1) begin
        @(posedge clk); #1;
        mpu_busy = 1'b1;
        if (eng_mode == 0) begin
          for (int k = 0; k < eng_len; k++) begin
            @(posedge clk); #1;
            if (rst) break;
          end
          mpu_rd_data = eng_rdata;
        end else begin
          for (int k = 0; k < 1000; k++) begin
            @(posedge clk); #1;
            if (rst || done != '0) break;
          end
        end
        mpu_busy = 1'b0;
      end
    end
  end

  initial begin : monitor
    logic       rd_pend;
    logic [7:0] rd_want;
    int         start_cyc;
    start_exp_t se;
    done_exp_t  de;
    rd_pend   = 1'b0;
    rd_want   = '0;
    start_cyc = 0;
    forever begin
      @(negedge clk);
      if (rd_pend) begin
        check("rdata after done", 32'(rdata), 32'(rd_want));
        rd_pend = 1'b0;
      end
      if (mpu_start) begin
        start_cyc = cyc;
        check("start not during busy", 32'(mpu_busy), 32'd0);
        check("start expected", 32'(start_q.size() != 0), 32'd1);
        if (start_q.size() != 0) begin
          se = start_q.pop_front();
          check("start grant", 32'(grant), 32'(se.grant));
          check("start address", 32'(mpu_address), 32'(se.addr));
          check("start rd_wr_sel", 32'(mpu_rd_wr_sel), 32'(se.rw));
          if (se.rw == WR) check("start wr_data", 32'(mpu_wr_data), 32'(se.wdata));
        end
      end
      if (done != '0) begin
        check("done expected", 32'(done_q.size() != 0), 32'd1);
        if (done_q.size() != 0) begin
          de = done_q.pop_front();
          check("done vector", 32'(done), 32'(de.done));
          if (de.lat != 0) check("start to done cycles", 32'(cyc - start_cyc), 32'(de.lat));
          rd_pend = 1'b1;
          rd_want = de.rdata;
        end
      end
    end
  end

  initial begin : watchdog
    #200_000;
    $display("FAIL global timeout: bench did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin : driver
    rst = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    eng_mode = 0; eng_len = 20; eng_rdata = 8'h71; exp_rd = '0;

    // 1. Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset grant", 32'(grant), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset rdata", 32'(rdata), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset start", 32'(mpu_start), 32'd0);
    check("reset rd_wr_sel", 32'(mpu_rd_wr_sel), 32'd1);
    check("reset address", 32'(mpu_address), 32'd0);
    check("reset wr_data", 32'(mpu_wr_data), 32'd0);
    repeat (5) @(negedge clk);
    check("idle start stays low", 32'(mpu_start), 32'd0);

    // 2. Single read by client 0
    set_client(0, RD, 7'h75, 8'h00);
    exp_start(3'b001, 7'h75, RD, 8'h00);
    exp_done(3'b001, 8'h71, 0);
    exp_rd = 8'h71;
    req = 3'b001;
    wait_done(100);
    req = 3'b000;
    repeat (3) @(negedge clk);

    // 3. Three writers held high: rotation 0,1,2,0,1,2 from a fresh reset
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    exp_rd = 8'h00;
    eng_len = 3;
    set_client(0, WR, 7'h6B, 8'hA1);
    set_client(1, WR, 7'h37, 8'hB2);
    set_client(2, WR, 7'h1C, 8'hC3);
    for (int i = 0; i < 6; i++) begin
      case (i % 3)
        0:       exp_start(3'b001, 7'h6B, WR, 8'hA1);
        1:       exp_start(3'b010, 7'h37, WR, 8'hB2);
        default: exp_start(3'b100, 7'h1C, WR, 8'hC3);
      endcase
      exp_done(3'(1 << (i % 3)), exp_rd, 0);
    end
    req = 3'b111;
    for (int i = 0; i < 6; i++) wait_done(60);
    req = 3'b000;
    repeat (3) @(negedge clk);

    // 4. Engine never raises busy: done after BUSY_RISE_MAX cycles in WAIT_RISE
    eng_mode = 1;
    set_client(0, WR, 7'h10, 8'h55);
    exp_start(3'b001, 7'h10, WR, 8'h55);
    exp_done(3'b001, exp_rd, int'(BUSY_RISE_MAX) + 1);
    req = 3'b001;
    wait_done(60);
    req = 3'b000;
    repeat (2) @(negedge clk);
    check("grant cleared after done", 32'(grant), 32'd0);
    check("no restart after done", 32'(mpu_start), 32'd0);

`ifdef MPU_ARB_TIMEOUT_EN
    // 5. Busy stuck high: watchdog forces done with 0xFF, next client served
    eng_mode = 2;
    set_client(1, RD, 7'h3B, 8'h00);
    set_client(2, WR, 7'h1C, 8'h77);
    exp_start(3'b010, 7'h3B, RD, 8'h00);
    exp_done(3'b010, 8'hFF, 0);
    exp_rd = 8'hFF;
    exp_start(3'b100, 7'h1C, WR, 8'h77);
    exp_done(3'b100, 8'hFF, 0);
    req = 3'b110;
    wait_done(400);
    req[1] = 1'b0;
    eng_mode = 0;
    check("err set on timeout", 32'(err), 32'd1);
    wait_done(100);
    req = 3'b000;
    check("err sticky", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
`else
    check("err tied low", 32'(err), 32'd0);
`endif

    // 6. Reset in WAIT_FALL: abandoned, then client 0 wins first after release
    eng_mode = 0; eng_len = 20; eng_rdata = 8'h99;
    set_client(1, RD, 7'h42, 8'h00);
    exp_start(3'b010, 7'h42, RD, 8'h00);
    req = 3'b010;
    wait_start(50);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("async reset grant", 32'(grant), 32'd0);
    check("async reset start", 32'(mpu_start), 32'd0);
    check("async reset done", 32'(done), 32'd0);
    exp_rd = 8'h00;
    set_client(0, WR, 7'h21, 8'h12);
    exp_start(3'b001, 7'h21, WR, 8'h12);
    exp_done(3'b001, 8'h00, 0);
    exp_start(3'b010, 7'h42, RD, 8'h00);
    exp_done(3'b010, 8'h99, 0);
    req = 3'b011;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_done(100);
    req[0] = 1'b0;
    wait_done(100);
    req = 3'b000;
    repeat (4) @(negedge clk);

    check("start queue drained", 32'(start_q.size()), 32'd0);
    check("done queue drained", 32'(done_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
